// File: rtl/crc_tx_framer_if.sv
// Payload-in / beat-out stream bundle for crc_tx_framer.
// The framer takes the slave view. A source/sink pair takes the master view.
interface crc_tx_framer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              tx_ready;

    modport master (
        output in_data, in_valid, in_last, tx_ready,
        input  in_ready, tx_data, tx_valid, tx_last
    );

    modport slave (
        input  in_data, in_valid, in_last, tx_ready,
        output in_ready, tx_data, tx_valid, tx_last
    );
endinterface

// File: rtl/crc_tx_framer.sv
// Transmit framer: passes payload beats through while accumulating a CRC,
// then appends the CRC MSB-first as CRC_W/DATA_W beats. CRC_W must be a multiple of DATA_W.
module crc_tx_framer #(
    parameter int unsigned       DATA_W  = 8,
    parameter int unsigned       CRC_W   = 16,
    parameter logic [CRC_W-1:0]  POLY    = 16'h1021,
    parameter logic [CRC_W-1:0]  INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0]  XOR_OUT = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    crc_tx_framer_if.slave     bus,
    output logic               busy,
    output logic               frame_done
);
    localparam int unsigned NBEATS = CRC_W / DATA_W;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PAYLOAD = 2'd1;
    localparam logic [1:0] CRC     = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [CRC_W-1:0]  crc, crc_nxt, crc_out;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] crc_slice;
    logic              slice_last;
    logic              done_nxt;

    // Bit-serial MSB-first CRC advance over one payload beat, no reflection.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0]  r;
        logic [DATA_W-1:0] dd;
        logic              fb;
        r  = c;
        dd = d;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            fb = r[CRC_W-1] ^ dd[DATA_W-1];
            r  = {r[CRC_W-2:0], 1'b0};
            dd = {dd[DATA_W-2:0], 1'b0};
            if (fb) r = r ^ POLY;
        end
        return r;
    endfunction

    assign crc_out    = crc ^ XOR_OUT;
    assign slice_last = (cnt == CNT_W'(NBEATS - 1));
    assign busy       = (state != IDLE);

    // Slice k = 0 is the most significant DATA_W bits of the final CRC.
    always_comb begin
        crc_slice = '0;
        for (int unsigned j = 0; j < NBEATS; j++) begin
            if (32'(cnt) == j) crc_slice = crc_out[CRC_W-1-j*DATA_W -: DATA_W];
        end
    end

    always_comb begin
        state_nxt    = state;
        crc_nxt      = crc;
        cnt_nxt      = cnt;
        done_nxt     = 1'b0;
        bus.in_ready = bus.tx_ready;
        bus.tx_valid = bus.in_valid;
        bus.tx_data  = bus.in_data;
        bus.tx_last  = 1'b0;
        case (state)
            IDLE, PAYLOAD: begin
                if (bus.in_valid && bus.tx_ready) begin
                    crc_nxt = crc_step(crc, bus.in_data);
                    if (bus.in_last) begin
                        state_nxt = CRC;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end
            end
            CRC: begin
                bus.in_ready = 1'b0;
                bus.tx_valid = 1'b1;
                bus.tx_data  = crc_slice;
                bus.tx_last  = slice_last;
                if (bus.tx_ready) begin
                    if (slice_last) begin
                        state_nxt = IDLE;
                        crc_nxt   = INIT;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            crc        <= INIT;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            crc        <= crc_nxt;
            cnt        <= cnt_nxt;
            frame_done <= done_nxt;
        end
    end
endmodule
